// File: rtl/sfifo_arb_pkg.sv
// Shared types and default constants for the FIFO write-side arbiter.
package sfifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;
  localparam int BURST_CNT_W    = 4;

endpackage

// File: rtl/sfifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter; master is the arbiter itself.
interface sfifo_wr_arbiter_if
  import sfifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          fifo_full;
  logic                          fifo_write_n;
  logic [DATA_WIDTH-1:0]         fifo_data_in;

  modport master (
    input  req, req_data, fifo_full,
    output ack, grant, busy, fifo_write_n, fifo_data_in
  );

  modport slave (
    output req, req_data, fifo_full,
    input  ack, grant, busy, fifo_write_n, fifo_data_in
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_idx,
// wrapping modulo NUM_REQ, so last_idx itself has lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand_s;
  logic             valid_s;
  logic [IDX_W-1:0] idx_s;

  // Scan candidates in priority order; the first hit sticks.
  always_comb begin
    cand_s  = '0;
    valid_s = 1'b0;
    idx_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s  = IDX_W'((int'(last_idx) + i) % NUM_REQ);
      idx_s   = (req[cand_s] && !valid_s) ? cand_s : idx_s;
      valid_s = valid_s | req[cand_s];
    end
  end

  assign valid = valid_s;
  assign idx   = idx_s;

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO among NUM_REQ producers; grants
// bursts of up to MAX_BURST words and never writes while the FIFO is full.
module sfifo_wr_arbiter
  import sfifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic               clock,
  input  logic               reset_n,
  sfifo_wr_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic                   pick_valid_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic [IDX_W-1:0]       g_idx_s;
  logic                   req_g_s;
  logic                   accept_s;
  logic [NUM_REQ-1:0]     ack_s;
  logic [DATA_WIDTH-1:0]  data_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (bus.req),
    .last_idx (last_grant_q),
    .valid    (pick_valid_s),
    .idx      (pick_idx_s)
  );

  // Owner index, accept decision and the write-port data mux.
  always_comb begin
    g_idx_s = '0;
    data_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      g_idx_s = grant_q[i] ? IDX_W'(i) : g_idx_s;
    end
    req_g_s  = bus.req[g_idx_s];
    accept_s = (state_q == BURST) && req_g_s && !bus.fifo_full;
    ack_s          = '0;
    ack_s[g_idx_s] = accept_s;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_s = (accept_s && (g_idx_s == IDX_W'(i)))
             ? bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] : data_s;
    end
  end

  // Next-state: arbitrate in IDLE, count accepted words in BURST.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s && !bus.fifo_full) begin
          state_d              = BURST;
          grant_d              = '0;
          grant_d[pick_idx_s]  = 1'b1;
          burst_cnt_d          = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!req_g_s || (accept_s && (burst_cnt_q == BURST_CNT_W'(MAX_BURST - 1)))) begin
          state_d      = IDLE;
          grant_d      = '0;
          last_grant_d = g_idx_s;
          burst_cnt_d  = '0;
        end else if (accept_s) begin
          burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d      = IDLE;
        grant_d      = '0;
        last_grant_d = IDX_W'(NUM_REQ - 1);
        burst_cnt_d  = '0;
      end
    endcase
  end

  // State registers; reset leaves producer 0 with first priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign bus.ack          = ack_s;
  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q == BURST);
  assign bus.fifo_write_n = !accept_s;
  assign bus.fifo_data_in = data_s;

endmodule
